// File: rtl/ram_responder.sv
// Memory-side responder for the cpu's 64-bit RAM port: single-port word array,
// byte-masked writes as read-modify-write, and a boot word at address 0 until overwritten.
module ram_responder #(
  parameter int          ADDR_W     = 28,
  parameter int          DEPTH      = 256,
  parameter logic [63:0] BOOT_WORD0 = 64'h1E12_1423_0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [7:0]        req_mask,
  input  logic              req_re,
  input  logic              req_we,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_ready,
  output logic [1:0]        dbg_state
);

  // Handshake: a request (req_re or req_we) is taken only at a posedge where the
  // FSM is IDLE and rsp_ready=1; rsp_ready stays low until that access completes.

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR_MERGE, WR_COMMIT} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [7:0]          mask_q, mask_d;
  logic                in_range_q, in_range_d;
  logic                ready_q, ready_d;
  logic [63:0]         rdata_q, rdata_d;
  logic                boot_valid_q, boot_valid_d;
  logic [63:0]         merged_q, merged_d;
  logic [63:0]         mem_rd_q;
  logic                mem_we;
  logic [63:0]         old_word;
  logic                req_in_range;

  logic [63:0] mem_q [DEPTH];

  assign req_in_range = (req_addr < ADDR_W'(DEPTH));

  // Word seen by reads and by the merge step: boot word shadows address 0.
  always_comb begin
    old_word = mem_rd_q;
    if (addr_q == '0 && boot_valid_q) old_word = BOOT_WORD0;
    else if (!in_range_q)             old_word = '0;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    in_range_d   = in_range_q;
    ready_d      = ready_q;
    rdata_d      = rdata_q;
    boot_valid_d = boot_valid_q;
    merged_d     = merged_q;
    mem_we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready_q && (req_re || req_we)) begin
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          mask_d     = req_mask;
          in_range_d = req_in_range;
          ready_d    = 1'b0;
          state_d    = req_re ? RD : WR_MERGE;
        end
      end
      RD: begin
        rdata_d = old_word;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      WR_MERGE: begin
        for (int j = 0; j < 8; j++) begin
          merged_d[8*j +: 8] = mask_q[j] ? wdata_q[8*j +: 8] : old_word[8*j +: 8];
        end
        state_d = WR_COMMIT;
      end
      WR_COMMIT: begin
        mem_we  = in_range_q;
        if (in_range_q && addr_q == '0) boot_valid_d = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      in_range_q   <= 1'b0;
      ready_q      <= 1'b1;
      rdata_q      <= '0;
      boot_valid_q <= 1'b1;
      merged_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      in_range_q   <= in_range_d;
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
      boot_valid_q <= boot_valid_d;
      merged_q     <= merged_d;
    end
  end

  // Array is not reset; a reset edge suppresses any pending commit.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[addr_q[IDX_W-1:0]] <= merged_q;
    mem_rd_q <= mem_q[req_addr[IDX_W-1:0]];
  end

  assign rsp_rdata = rdata_q;
  assign rsp_ready = ready_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: driver tasks queue expected results and a
// negedge monitor checks latency and read data whenever rsp_ready rises.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [27:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_mask = '0;
  logic        req_re = 1'b0;
  logic        req_we = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_ready;
  logic [1:0]  dbg_state;

  localparam logic [63:0] BOOT = 64'h1E12_1423_0000_0000;

  ram_responder dut (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_mask(req_mask), .req_re(req_re), .req_we(req_we),
    .rsp_rdata(rsp_rdata), .rsp_ready(rsp_ready), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];
  bit          kind_q[$];   // 1 = read, 0 = write
  bit          mon_en = 1'b0;
  int          low_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts ready-low cycles and checks each completion against the queues.
  always @(negedge clk) begin
    if (!mon_en) begin
      low_cnt = 0;
    end else if (!rsp_ready) begin
      low_cnt++;
    end else if (low_cnt > 0) begin
      if (kind_q.size() == 0) begin
        check("unexpected_completion", 64'(low_cnt), 64'd0);
      end else begin
        bit is_rd;
        is_rd = kind_q.pop_front();
        check(is_rd ? "read_latency" : "write_latency", 64'(low_cnt), is_rd ? 64'd1 : 64'd2);
        if (is_rd) begin
          if (exp_q.size() == 0) check("read_no_expect", rsp_rdata, 64'hX);
          else check("read_data", rsp_rdata, exp_q.pop_front());
        end
      end
      low_cnt = 0;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!rsp_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_ready) check("ready_timeout", 64'(rsp_ready), 64'd1);
  endtask

  // Drive one request at a negedge; scramble req_* after acceptance to prove latching.
  task automatic issue(input bit re, input bit we, input logic [27:0] a,
                       input logic [63:0] d, input logic [7:0] m, input logic [63:0] exp);
    @(negedge clk);
    wait_ready();
    req_re = re; req_we = we; req_addr = a; req_wdata = d; req_mask = m;
    kind_q.push_back(re);
    if (re) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    req_re = 1'b0; req_we = 1'b0;
    req_addr = 28'($urandom_range(0, 255));
    req_wdata = {$urandom, $urandom};
    req_mask = 8'($urandom_range(0, 255));
    @(negedge clk);
    wait_ready();
  endtask

  task automatic rd(input logic [27:0] a, input logic [63:0] exp);
    issue(1'b1, 1'b0, a, 64'h0, 8'h00, exp);
  endtask

  task automatic wr(input logic [27:0] a, input logic [63:0] d, input logic [7:0] m);
    issue(1'b0, 1'b1, a, d, m, 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_ready", 64'(rsp_ready), 64'd1);
    check("reset_rdata", rsp_rdata, 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    kind_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    do_reset();

    // Boot fetch and a mask=0 write at address 0 that must commit the boot word.
    rd(28'd0, BOOT);
    wr(28'd0, 64'h1234_5678_9ABC_DEF0, 8'h00);
    rd(28'd0, BOOT);

    // Masked read-modify-write.
    wr(28'd5, 64'h1111_2222_3333_4444, 8'hFF);
    wr(28'd5, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
    rd(28'd5, 64'h1111_2222_CCCC_DDDD);
    wr(28'd5, 64'h0000_0000_0000_00EE, 8'h01);
    rd(28'd5, 64'h1111_2222_CCCC_DDEE);

    // Boot override, then reset restores the boot word.
    wr(28'd0, 64'h0000_0000_FFFF_FFFF, 8'h0F);
    rd(28'd0, 64'h1E12_1423_FFFF_FFFF);
    do_reset();
    rd(28'd0, BOOT);

    // Out of range: discarded write, zero read, no aliasing onto 44.
    wr(28'd44, 64'h4444_4444_0000_0044, 8'hFF);
    wr(28'd300, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    rd(28'd300, 64'h0);
    rd(28'd44, 64'h4444_4444_0000_0044);
    rd(28'h100_0000, 64'h0);

    // re and we together behave as a read; array[7] keeps its value.
    wr(28'd7, 64'h7777_0000_7777_0000, 8'hFF);
    issue(1'b1, 1'b1, 28'd7, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 64'h7777_0000_7777_0000);
    rd(28'd7, 64'h7777_0000_7777_0000);

    // Hold req_re high: accepted at E0, E2, E4 -> three reads.
    @(negedge clk);
    req_re = 1'b1; req_addr = 28'd5;
    repeat (3) begin
      kind_q.push_back(1'b1);
      exp_q.push_back(64'h1111_2222_CCCC_DDEE);
    end
    repeat (5) @(posedge clk);
    #1 req_re = 1'b0;
    @(negedge clk);
    wait_ready();
    @(negedge clk);
    check("held_reads_drained", 64'(kind_q.size()), 64'd0);

    // Reset during WR_COMMIT aborts the write to 9.
    wr(28'd9, 64'h9999_9999_9999_9999, 8'hFF);
    @(negedge clk);
    req_we = 1'b1; req_addr = 28'd9; req_wdata = 64'h0; req_mask = 8'hFF;
    @(posedge clk);
    #1 req_we = 1'b0;
    @(posedge clk);
    #1 check("in_wr_commit", 64'(dbg_state), 64'd3);
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 64'(rsp_ready), 64'd1);
    check("midrst_rdata", rsp_rdata, 64'd0);
    kind_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
    rd(28'd9, 64'h9999_9999_9999_9999);

    repeat (3) @(negedge clk);
    check("queues_empty", 64'(kind_q.size() + exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
